// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode stage with 16x16 register file, load-use stall and ID/EX buffer; define REGFILE_BYPASS_EN for write-through reads
module id_ex_stage #(
    parameter int DATA_W   = 16,
    parameter int RF_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              nop_in,
    input  logic [15:0]       inst_in,
    input  logic [15:0]       pc_in,
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              valid_out,
    output logic [15:0]       pc_out,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_out,
    output logic [3:0]        rd_addr,
    output logic [3:0]        rs_addr,
    output logic [3:0]        rt_addr,
    output logic [3:0]        alu_fn,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              br_eq,
    output logic              br_ne,
    output logic              illegal
);

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h8;
    localparam logic [3:0] OP_SW    = 4'hB;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_NOP   = 4'hF;

    // Register file storage; entry 0 is never written so it stays 0
    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] rf_d [RF_DEPTH];

    // ID/EX buffer
    logic              valid_q,     valid_d;
    logic [15:0]       pc_q,        pc_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [3:0]        rd_addr_q,   rd_addr_d;
    logic [3:0]        rs_addr_q,   rs_addr_d;
    logic [3:0]        rt_addr_q,   rt_addr_d;
    logic [3:0]        alu_fn_q,    alu_fn_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              br_eq_q,     br_eq_d;
    logic              br_ne_q,     br_ne_d;
    logic              illegal_q,   illegal_d;

    // Decoded fields of the instruction sitting in IF/ID
    logic [3:0]        op;
    logic [3:0]        rs_a;
    logic [3:0]        rt_a;
    logic              dec_reg_write;
    logic              dec_mem_read;
    logic              dec_mem_write;
    logic              dec_br_eq;
    logic              dec_br_ne;
    logic              dec_illegal;
    logic              dec_uses_rt;
    logic [3:0]        dec_alu_fn;
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;
    logic              rs_hit;
    logic              rt_hit;
    logic              stall_c;
    logic              load;

    assign op   = inst_in[15:12];
    assign rs_a = inst_in[11:8];
    assign rt_a = inst_in[7:4];

    // Opcode decode into control bits; unknown opcodes are flagged illegal but still issue
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_br_eq     = 1'b0;
        dec_br_ne     = 1'b0;
        dec_illegal   = 1'b0;
        dec_uses_rt   = 1'b0;
        dec_alu_fn    = 4'h0;
        case (op)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_uses_rt   = 1'b1;
                dec_alu_fn    = inst_in[3:0];
            end
            OP_LW: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                dec_br_eq     = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_BNE: begin
                dec_br_ne     = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_NOP: begin
                dec_uses_rt   = 1'b0;
            end
            default: begin
                dec_illegal   = 1'b1;
            end
        endcase
    end

    // Combinational operand reads; R0 is hard-wired to zero
    always_comb begin
        rs_rd = (rs_a == 4'h0) ? '0 : rf_q[rs_a];
        rt_rd = (rt_a == 4'h0) ? '0 : rf_q[rt_a];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && (wb_addr != 4'h0) && (wb_addr == rs_a)) rs_rd = wb_data;
        if (wb_en && (wb_addr != 4'h0) && (wb_addr == rt_a)) rt_rd = wb_data;
`endif
    end

    // Load-use detection against the load now in ID/EX; clears as soon as valid_q drops
    always_comb begin
        rs_hit  = (rd_addr_q == rs_a);
        rt_hit  = dec_uses_rt & (rd_addr_q == rt_a);
        stall_c = valid_q & mem_read_q & (rd_addr_q != 4'h0) & (rs_hit | rt_hit)
                  & ~nop_in & ~flush;
    end

    assign stall = stall_c;

    // Writeback port update; writes to R0 are dropped
    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != 4'h0)) rf_d[wb_addr] = wb_data;
    end

    // Register file flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Next ID/EX contents: flush, stall and nop_in all insert an all-zero bubble
    always_comb begin
        load        = ~flush & ~stall_c & ~nop_in;
        valid_d     = 1'b0;
        pc_d        = '0;
        rs_data_d   = '0;
        rt_data_d   = '0;
        imm_d       = '0;
        rd_addr_d   = '0;
        rs_addr_d   = '0;
        rt_addr_d   = '0;
        alu_fn_d    = '0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        br_eq_d     = 1'b0;
        br_ne_d     = 1'b0;
        illegal_d   = 1'b0;
        if (load) begin
            valid_d     = 1'b1;
            pc_d        = pc_in;
            rs_data_d   = rs_rd;
            rt_data_d   = rt_rd;
            imm_d       = {{(DATA_W-4){inst_in[3]}}, inst_in[3:0]};
            rd_addr_d   = inst_in[11:8];
            rs_addr_d   = rs_a;
            rt_addr_d   = rt_a;
            alu_fn_d    = dec_alu_fn;
            reg_write_d = dec_reg_write;
            mem_read_d  = dec_mem_read;
            mem_write_d = dec_mem_write;
            br_eq_d     = dec_br_eq;
            br_ne_d     = dec_br_ne;
            illegal_d   = dec_illegal;
        end
    end

    // ID/EX buffer flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rd_addr_q   <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            alu_fn_q    <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            br_eq_q     <= 1'b0;
            br_ne_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rd_addr_q   <= rd_addr_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            alu_fn_q    <= alu_fn_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            br_eq_q     <= br_eq_d;
            br_ne_q     <= br_ne_d;
            illegal_q   <= illegal_d;
        end
    end

    assign valid_out = valid_q;
    assign pc_out    = pc_q;
    assign rs_data   = rs_data_q;
    assign rt_data   = rt_data_q;
    assign imm_out   = imm_q;
    assign rd_addr   = rd_addr_q;
    assign rs_addr   = rs_addr_q;
    assign rt_addr   = rt_addr_q;
    assign alu_fn    = alu_fn_q;
    assign reg_write = reg_write_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign br_eq     = br_eq_q;
    assign br_ne     = br_ne_q;
    assign illegal   = illegal_q;

endmodule
